videoram_port2_arbiter: RTL

- Shares the second Avalon port (s2) of the 2500 x 32-bit dual-port video RAM between two hardware requesters.
  - Display fetch reader: latency-critical, high priority.
  - Barcode capture line writer: bulk, starvation-protected.
- Arbitrates one access per cycle and range-checks addresses against the RAM depth.
- Returns read data with a fixed 1-cycle latency, with a valid strobe aligned to the RAM output.

---
 rtl/videoram_port2_arbiter_if.sv | 58 +++++
 rtl/videoram_port2_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/videoram_port2_arbiter_if.sv
// videoram_port2_arbiter_if
//   Bundles the signals around the shared s2 port of the video RAM:
//   the display reader handshake, the barcode line writer handshake and
//   the Avalon s2 connection to the RAM itself.
//
//   Reader:  rd_req, rd_addr (to arbiter); rd_gnt, rd_valid, rd_data, rd_err (from arbiter)
//   Writer:  wr_req, wr_addr, wr_data, wr_be (to arbiter); wr_gnt, wr_err (from arbiter)
//   RAM s2:  mem_address, mem_chipselect, mem_write, mem_writedata,
//            mem_byteenable, mem_clken (from arbiter); mem_readdata (to arbiter)
//
//   Modport slave is the arbiter's view; modport master is the view of
//   whatever surrounds it (requesters plus the RAM).
interface videoram_port2_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_err;

  logic                  wr_req;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  wr_gnt;
  logic                  wr_err;

  logic [ADDR_W-1:0]     mem_address;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic [DATA_W-1:0]     mem_writedata;
  logic [DATA_W/8-1:0]   mem_byteenable;
  logic                  mem_clken;
  logic [DATA_W-1:0]     mem_readdata;

  modport slave (
    input  rd_req, rd_addr,
    output rd_gnt, rd_valid, rd_data, rd_err,
    input  wr_req, wr_addr, wr_data, wr_be,
    output wr_gnt, wr_err,
    output mem_address, mem_chipselect, mem_write, mem_writedata,
           mem_byteenable, mem_clken,
    input  mem_readdata
  );

  modport master (
    output rd_req, rd_addr,
    input  rd_gnt, rd_valid, rd_data, rd_err,
    output wr_req, wr_addr, wr_data, wr_be,
    input  wr_gnt, wr_err,
    input  mem_address, mem_chipselect, mem_write, mem_writedata,
           mem_byteenable, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/videoram_port2_arbiter.sv
// videoram_port2_arbiter
//   Shares port s2 of the 2500 x 32 dual-port video RAM between the display
//   fetch reader (high priority) and the barcode capture line writer
//   (starvation protected). One access is performed per cycle, addresses at
//   or beyond DEPTH are refused at the RAM but still granted, and read data
//   comes back one cycle after the grant with a matching valid strobe.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous active-high reset
//     bus    videoram_port2_arbiter_if.slave: reader/writer handshakes and
//            the Avalon s2 connection to the RAM
module videoram_port2_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2500,
  parameter int MAX_WAIT = 8
) (
  input logic                       clk,
  input logic                       reset,
  videoram_port2_arbiter_if.slave   bus
);

  localparam int               BE_W       = DATA_W / 8;
  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]  DEPTH_C    = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]       MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt;
  logic              rd_valid_q;
  logic              rd_err_q;

  logic              rd_oor;
  logic              wr_oor;
  logic              wr_win;
  logic              rd_win;
  logic              rd_gnt_c;
  logic              wr_gnt_c;
  logic              wr_err_c;
  logic              cs_c;
  logic              write_c;
  logic [ADDR_W-1:0] addr_c;
  logic [BE_W-1:0]   be_c;

  assign rd_oor = ({1'b0, bus.rd_addr} >= DEPTH_C);
  assign wr_oor = ({1'b0, bus.wr_addr} >= DEPTH_C);

  // Writer wins only when the reader is idle or the writer has been held
  // off for MAX_WAIT cycles; everything is masked while reset is high.
  assign wr_win = !reset && bus.wr_req && (!bus.rd_req || wait_cnt == MAX_WAIT_C);
  assign rd_win = !reset && !wr_win && bus.rd_req;

  // Grant and s2 drive. Out-of-range accesses are granted so the requester
  // can move on, but chipselect stays low so the RAM never sees them.
  always_comb begin
    rd_gnt_c = 1'b0;
    wr_gnt_c = 1'b0;
    wr_err_c = 1'b0;
    cs_c     = 1'b0;
    write_c  = 1'b0;
    addr_c   = '0;
    be_c     = '0;
    if (wr_win) begin
      wr_gnt_c = 1'b1;
      wr_err_c = wr_oor;
      cs_c     = !wr_oor;
      write_c  = !wr_oor;
      addr_c   = bus.wr_addr;
      be_c     = bus.wr_be;
    end else if (rd_win) begin
      rd_gnt_c = 1'b1;
      cs_c     = !rd_oor;
      addr_c   = bus.rd_addr;
      be_c     = '1;
    end
  end

  // Starvation counter: counts cycles the writer is left waiting and
  // saturates at MAX_WAIT, which is the level that forces a write grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!bus.wr_req || wr_gnt_c) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_WAIT_C) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Read return pipeline, aligned with the RAM's one-cycle read latency.
  // Reset drops any read that was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_gnt_c;
      rd_err_q   <= rd_gnt_c && rd_oor;
    end
  end

  assign bus.rd_gnt         = rd_gnt_c;
  assign bus.wr_gnt         = wr_gnt_c;
  assign bus.wr_err         = wr_err_c;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_err         = rd_err_q;
  // A refused read has no RAM data behind it, so it returns zero.
  assign bus.rd_data        = rd_err_q ? '0 : bus.mem_readdata;

  assign bus.mem_address    = addr_c;
  assign bus.mem_chipselect = cs_c;
  assign bus.mem_write      = write_c;
  assign bus.mem_writedata  = bus.wr_data;
  assign bus.mem_byteenable = be_c;
  assign bus.mem_clken      = 1'b1;

endmodule
